// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor.
// The predictor sits on the slave side; fetch and execute together drive the master side.
interface branch_predictor_if;
    // Fetch lookup request and registered prediction
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;

    // Execute-stage resolution and training results
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output lookup_valid, lookup_pc,
        input  pred_valid, pred_taken, pred_target,
        output update_valid, update_pc, update_taken, update_target, update_pred_taken,
        input  mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        output pred_valid, pred_taken, pred_target,
        input  update_valid, update_pc, update_taken, update_target, update_pred_taken,
        output mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Lookups read the registered table and answer one cycle later. Updates write the
// table at the same edge. A lookup and an update to the same entry at one edge
// therefore see the pre-update contents (read-before-write).
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Saturating counter step: move toward ST on taken, toward SNT on not taken.
    function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
        case (c)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            ST:      return taken ? ST  : WT;
            default: return WNT;
        endcase
    endfunction

    // Table state
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];
    ctr_e             ctr_d    [ENTRIES];

    // Prediction and statistics outputs
    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic        mispredict_q, mispredict_d;
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Address decomposition; pc[1:0] carries no information for word-aligned fetch
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  lk_hit;
    logic                  up_hit;
    logic                  unused_pc_bits;

    assign lk_idx         = bus.lookup_pc[INDEX_BITS+1:2];
    assign lk_tag         = bus.lookup_pc[31:INDEX_BITS+2];
    assign up_idx         = bus.update_pc[INDEX_BITS+1:2];
    assign up_tag         = bus.update_pc[31:INDEX_BITS+2];
    assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign unused_pc_bits = ^bus.update_pc[1:0];

    // Lookup: form the prediction from the current (pre-update) table contents
    always_comb begin
        pred_valid_d  = bus.lookup_valid;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (bus.lookup_valid) begin
            pred_taken_d  = lk_hit && ctr_q[lk_idx][1];
            pred_target_d = pred_taken_d ? target_q[lk_idx] : bus.lookup_pc + 32'd4;
        end
    end

    // Update: train the hit entry or allocate over whatever occupies the slot
    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        target_d           = target_q;
        ctr_d              = ctr_q;
        mispredict_d       = 1'b0;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bus.update_valid) begin
            if (up_hit) begin
                ctr_d[up_idx] = ctr_step(ctr_q[up_idx], bus.update_taken);
                if (bus.update_taken) begin
                    target_d[up_idx] = bus.update_target;
                end
            end else begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.update_target;
                ctr_d[up_idx]    = bus.update_taken ? WT : WNT;
            end
            mispredict_d   = bus.update_taken != bus.update_pred_taken;
            branch_count_d = branch_count_q + 32'd1;
            if (mispredict_d) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    // State registers; reset clears the whole table and all outputs immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            pred_valid_q       <= 1'b0;
            pred_taken_q       <= 1'b0;
            pred_target_q      <= '0;
            mispredict_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            pred_valid_q       <= pred_valid_d;
            pred_taken_q       <= pred_taken_d;
            pred_target_q      <= pred_target_d;
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.pred_valid       = pred_valid_q;
    assign bus.pred_taken       = pred_taken_q;
    assign bus.pred_target      = pred_target_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue-based scoreboard.
// Stimulus pushes the hand-computed response; a monitor pops on each DUT response.
module tb_branch_predictor;
    logic clk;
    logic rst_n;

    branch_predictor_if bif();

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
    } pred_exp_t;

    typedef struct {
        logic        mis;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } upd_exp_t;

    pred_exp_t pred_q[$];
    upd_exp_t  upd_q[$];
    int        checks = 0;
    int        errors = 0;
    logic      upd_pending = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lookup(input logic [31:0] pc, input logic etaken, input logic [31:0] etarget);
        pred_exp_t e;
        bif.lookup_valid = 1'b1;
        bif.lookup_pc    = pc;
        e.taken  = etaken;
        e.target = etarget;
        pred_q.push_back(e);
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                                input logic ptaken, input logic emis, input logic [31:0] ebc,
                                input logic [31:0] emc);
        upd_exp_t e;
        bif.update_valid      = 1'b1;
        bif.update_pc         = pc;
        bif.update_taken      = taken;
        bif.update_target     = target;
        bif.update_pred_taken = ptaken;
        e.mis  = emis;
        e.bcnt = ebc;
        e.mcnt = emc;
        upd_q.push_back(e);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic etaken, input logic [31:0] etarget);
        drive_lookup(pc, etaken, etarget);
        tick();
        bif.lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                          input logic ptaken, input logic emis, input logic [31:0] ebc,
                          input logic [31:0] emc);
        drive_update(pc, taken, target, ptaken, emis, ebc, emc);
        tick();
        bif.update_valid = 1'b0;
    endtask

    // Remember which edges accepted an update so the monitor knows when results are due
    always @(posedge clk) begin
        upd_pending <= bif.update_valid && rst_n;
    end

    // Monitor: pop and compare on every prediction and every update result
    always @(negedge clk) begin
        if (bif.pred_valid === 1'b1) begin
            if (pred_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pred_unexpected: got pred_valid=1, expected no prediction");
            end else begin
                pred_exp_t e;
                e = pred_q.pop_front();
                chk("pred_taken", {31'd0, bif.pred_taken}, {31'd0, e.taken});
                chk("pred_target", bif.pred_target, e.target);
            end
        end
        if (upd_pending) begin
            if (upd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_unexpected: got update result, expected none queued");
            end else begin
                upd_exp_t u;
                u = upd_q.pop_front();
                chk("mispredict", {31'd0, bif.mispredict}, {31'd0, u.mis});
                chk("branch_count", bif.branch_count, u.bcnt);
                chk("mispredict_count", bif.mispredict_count, u.mcnt);
            end
        end
    end

    initial begin
        rst_n                 = 1'b0;
        bif.lookup_valid      = 1'b0;
        bif.lookup_pc         = '0;
        bif.update_valid      = 1'b0;
        bif.update_pc         = '0;
        bif.update_taken      = 1'b0;
        bif.update_target     = '0;
        bif.update_pred_taken = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_valid", {31'd0, bif.pred_valid}, 32'd0);
        chk("rst_pred_target", bif.pred_target, 32'd0);
        chk("rst_mispredict", {31'd0, bif.mispredict}, 32'd0);
        chk("rst_branch_count", bif.branch_count, 32'd0);
        chk("rst_mispredict_count", bif.mispredict_count, 32'd0);
        rst_n = 1'b1;

        // 1: cold lookup
        lookup(32'h100, 1'b0, 32'h104);

        // 2: first taken update allocates at WT
        update(32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'd1, 32'd1);
        lookup(32'h100, 1'b1, 32'h80);

        // 3: saturate at ST, then two not-taken steps down to WNT
        update(32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 32'd2, 32'd1);
        update(32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 32'd3, 32'd1);
        update(32'h100, 1'b0, 32'h80, 1'b1, 1'b1, 32'd4, 32'd2);
        lookup(32'h100, 1'b1, 32'h80);
        update(32'h100, 1'b0, 32'h80, 1'b1, 1'b1, 32'd5, 32'd3);
        lookup(32'h100, 1'b0, 32'h104);

        // 4: aliasing on the same index with a different tag
        update(32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'd6, 32'd4);
        lookup(32'h200, 1'b0, 32'h204);
        update(32'h200, 1'b0, 32'h300, 1'b0, 1'b0, 32'd7, 32'd4);
        lookup(32'h100, 1'b0, 32'h104);
        lookup(32'h200, 1'b0, 32'h204);

        // 5: reallocate 0x100 at WNT, then lookup and taken update at the same edge
        update(32'h100, 1'b0, 32'h40, 1'b0, 1'b0, 32'd8, 32'd4);
        drive_lookup(32'h100, 1'b0, 32'h104);
        drive_update(32'h100, 1'b1, 32'h44, 1'b0, 1'b1, 32'd9, 32'd5);
        tick();
        bif.lookup_valid = 1'b0;
        bif.update_valid = 1'b0;
        lookup(32'h100, 1'b1, 32'h44);

        // Idle lookup cycle: pred_valid drops, direction and target hold
        tick();
        chk("hold_pred_valid", {31'd0, bif.pred_valid}, 32'd0);
        chk("hold_pred_taken", {31'd0, bif.pred_taken}, 32'd1);
        chk("hold_pred_target", bif.pred_target, 32'h44);

        // Fall-through target wraps at the top of the address space
        lookup(32'hFFFF_FFFC, 1'b0, 32'h0);

        // 6: asynchronous reset between edges with state trained and outputs non-zero
        lookup(32'h100, 1'b1, 32'h44);
        update(32'h100, 1'b1, 32'h44, 1'b0, 1'b1, 32'd10, 32'd6);
        #5;
        rst_n = 1'b0;
        #1;
        chk("arst_pred_taken", {31'd0, bif.pred_taken}, 32'd0);
        chk("arst_pred_target", bif.pred_target, 32'd0);
        chk("arst_mispredict", {31'd0, bif.mispredict}, 32'd0);
        chk("arst_branch_count", bif.branch_count, 32'd0);
        chk("arst_mispredict_count", bif.mispredict_count, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        lookup(32'h100, 1'b0, 32'h104);
        chk("post_rst_branch_count", bif.branch_count, 32'd0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && (pred_q.size() != 0 || upd_q.size() != 0); i++) begin
            tick();
        end
        tick();
        chk("pred_queue_drained", pred_q.size(), 32'd0);
        chk("upd_queue_drained", upd_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000 time units");
        $fatal(1, "timeout");
    end
endmodule
